// File: rtl/fixed_point_pkg.sv
// fixed_point_pkg: shared fixed-point defaults, FSM encoding and saturation limits
package fixed_point_pkg;
    localparam int FP_WIDTH     = 14;
    localparam int FP_FRAC_BITS = 7;
    typedef enum logic [1:0] {IDLE, DIV, ROUND} fp_state_t;
    localparam logic signed [FP_WIDTH-1:0] MAX_POS = {1'b0, {(FP_WIDTH-1){1'b1}}};
    localparam logic signed [FP_WIDTH-1:0] MIN_NEG = {1'b1, {(FP_WIDTH-1){1'b0}}};
endpackage

// File: rtl/fixed_point_round_sat.sv
// fixed_point_round_sat: round-half-to-even on a magnitude, apply sign, saturate to WIDTH bits
module fixed_point_round_sat
    import fixed_point_pkg::*;
#(
    parameter int WIDTH = FP_WIDTH,
    parameter int MAG_W = FP_WIDTH + FP_FRAC_BITS
) (
    input  logic [MAG_W-1:0]        mag,
    input  logic                    round,
    input  logic                    sticky,
    input  logic                    sign,
    output logic signed [WIDTH-1:0] result
);
    localparam logic [MAG_W:0] LIM_POS = (MAG_W+1)'((64'd1 << (WIDTH-1)) - 64'd1);
    localparam logic [MAG_W:0] LIM_NEG = LIM_POS + 1'b1;
    localparam logic signed [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [MAG_W:0] inc;
    logic [WIDTH-1:0] low;

    assign inc = {1'b0, mag} + (MAG_W+1)'(round & (sticky | mag[0]));
    assign low = inc[WIDTH-1:0];
    // negating a zero magnitude stays zero, so no negative zero appears
    assign result = sign ? (inc > LIM_NEG ? SAT_NEG : -low)
                         : (inc > LIM_POS ? SAT_POS : low);
endmodule

// File: rtl/fixed_point_divider.sv
// fixed_point_divider: signed fixed-point a/b by restoring division, one quotient bit per cycle,
// with round-half-to-even, saturation and fixed latency.
module fixed_point_divider
    import fixed_point_pkg::*;
#(
    parameter int WIDTH     = FP_WIDTH,
    parameter int FRAC_BITS = FP_FRAC_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic                    busy,
    output logic                    data_valid,
    output logic signed [WIDTH-1:0] Div_result,
    output logic                    div_by_zero
);
    localparam int N  = WIDTH + FRAC_BITS + 1;
    localparam int CW = $clog2(N);

    fp_state_t state, state_nx;
    logic sign, zero_b;
    logic [WIDTH-1:0] divisor, rem, mag_a, mag_b;
    logic [N-1:0] qr;
    logic [CW-1:0] cnt;
    logic [WIDTH:0] trial, diff;
    logic ge;
    logic signed [WIDTH-1:0] rounded;

    assign mag_a = a[WIDTH-1] ? -a : a;
    assign mag_b = b[WIDTH-1] ? -b : b;
    assign trial = {rem, qr[N-1]};
    assign diff  = trial - {1'b0, divisor};
    assign ge    = trial >= {1'b0, divisor};
    assign busy  = state != IDLE;

    always_comb begin
        state_nx = state == IDLE ? (start ? DIV : IDLE)
                 : state == DIV  ? (cnt == CW'(N-1) ? ROUND : DIV)
                 : IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // qr starts as the shifted dividend and fills with quotient bits from the right
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sign        <= 1'b0;
            zero_b      <= 1'b0;
            divisor     <= '0;
            rem         <= '0;
            qr          <= '0;
            cnt         <= '0;
            data_valid  <= 1'b0;
            Div_result  <= '0;
            div_by_zero <= 1'b0;
        end else begin
            data_valid <= state == ROUND;
            if (state == IDLE && start) begin
                sign    <= a[WIDTH-1] ^ b[WIDTH-1];
                zero_b  <= b == '0;
                divisor <= mag_b;
                rem     <= '0;
                qr      <= {mag_a, {(FRAC_BITS+1){1'b0}}};
                cnt     <= '0;
            end else if (state == DIV) begin
                rem <= ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
                qr  <= {qr[N-2:0], ge};
                cnt <= cnt + 1'b1;
            end
            if (state == ROUND) begin
                Div_result  <= rounded;
                div_by_zero <= zero_b;
            end
        end
    end

    // a zero divisor yields an all-ones quotient, which saturates by the sign of a
    fixed_point_round_sat #(.WIDTH(WIDTH), .MAG_W(N-1)) u_round_sat (
        .mag    (qr[N-1:1]),
        .round  (qr[0]),
        .sticky (rem != '0),
        .sign   (sign),
        .result (rounded)
    );
endmodule

// File: tb/tb_fixed_point_divider.sv
// tb_fixed_point_divider: scoreboard bench comparing every result against an integer golden model
module tb_fixed_point_divider;
    import fixed_point_pkg::*;

    localparam int W = FP_WIDTH;
    localparam int F = FP_FRAC_BITS;
    localparam int N = W + F + 1;

    typedef struct {
        longint res;
        bit     dbz;
        longint acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic signed [W-1:0] a = '0, b = '0;
    logic busy, data_valid, div_by_zero;
    logic signed [W-1:0] Div_result;

    exp_t sb[$];
    longint cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    fixed_point_divider dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .data_valid  (data_valid),
        .Div_result  (Div_result),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint model(input longint x, input longint y);
        longint mx, my, num, q, t;
        bit st, neg;
        if (y == 0) return x < 0 ? longint'(MIN_NEG) : longint'(MAX_POS);
        mx  = x < 0 ? -x : x;
        my  = y < 0 ? -y : y;
        neg = (x < 0) != (y < 0);
        num = mx << (F + 1);
        q   = num / my;
        st  = (num % my) != 0;
        t   = q >> 1;
        if ((q & 1) == 1 && (st || (t & 1) == 1)) t++;
        if (neg) return t > (longint'(1) << (W - 1)) ? longint'(MIN_NEG) : -t;
        return t > longint'(MAX_POS) ? longint'(MAX_POS) : t;
    endfunction

    function automatic logic signed [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return MIN_NEG;
            2: return MAX_POS;
            3: return -1;
            4: return 1;
            default: return W'($urandom);
        endcase
    endfunction

    always @(negedge clk) begin
        if (data_valid) begin
            exp_t e;
            if (sb.size() == 0) check("spurious_valid", 1, 0);
            else begin
                e = sb.pop_front();
                check("result", Div_result, e.res);
                check("div_by_zero", div_by_zero, e.dbz);
                check("latency", cyc - e.acc, N + 1);
            end
        end
    end

    // start is presented for exactly one edge; inputs are scrambled afterwards
    task automatic issue(input logic signed [W-1:0] x, input logic signed [W-1:0] y);
        exp_t e;
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        e.res = model(x, y);
        e.dbz = y == 0;
        e.acc = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", data_valid, 0);
        check("rst_result", Div_result, 0);
        check("rst_dbz", div_by_zero, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        issue(192, 64);
        check("busy_after_accept", busy, 1);
        wait_idle();
        check("busy_after_done", busy, 0);
        issue(-128, 384); wait_idle();
        issue(1, 256);    wait_idle();
        issue(3, 256);    wait_idle();
        issue(8191, 1);   wait_idle();
        issue(-8192, 1);  wait_idle();
        issue(-8192, -1); wait_idle();
        issue(100, 0);    wait_idle();
        issue(-5, 0);     wait_idle();
        issue(0, 0);      wait_idle();
        issue(0, -7);     wait_idle();

        issue(640, -192);
        repeat (5) @(negedge clk);
        a = 1; b = 1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        issue(-300, 77);
        repeat (21) @(negedge clk);
        a = 2; b = 1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (30) @(negedge clk);

        issue(1000, 3);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_valid", data_valid, 0);
        check("abort_result", Div_result, 0);
        check("abort_dbz", div_by_zero, 0);
        sb.delete();
        repeat (30) @(negedge clk);
        rst = 1'b1;
        issue(-1000, 3);
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            issue(pick(), pick());
            repeat (N) @(negedge clk);
        end
        wait_idle();
        repeat (30) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fixed_point_divider.md
FIXED_POINT_DIVIDER -- requirements
Module: fixed_point_divider

Interface
REQ-001 Parameter WIDTH, default 14, SHALL set the total width of operands and result in two's complement.
REQ-002 Parameter FRAC_BITS, default 7, SHALL set the number of fractional bits (Q6.7 at defaults).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 start  input  1  SHALL request a division; it is sampled only in IDLE.
REQ-006 a  input  WIDTH signed  SHALL be the dividend, captured on the edge that accepts start.
REQ-007 b  input  WIDTH signed  SHALL be the divisor, captured on the same edge as a.
REQ-008 busy  output  1  SHALL be high from the edge after acceptance until data_valid is asserted.
REQ-009 data_valid  output  1  SHALL pulse high for exactly one cycle when Div_result is updated.
REQ-010 Div_result  output  WIDTH signed  SHALL hold the rounded, saturated quotient a/b until the next result.
REQ-011 div_by_zero  output  1  SHALL be updated with Div_result: 1 if captured b==0, else 0.

Function
REQ-012 The FSM SHALL have states IDLE, DIV, ROUND; transitions: IDLE->DIV on start, DIV->ROUND after the last iteration, ROUND->IDLE unconditionally.
REQ-013 On acceptance the block SHALL register sign = a[MSB]^b[MSB] and the magnitudes |a| and |b| as WIDTH-bit unsigned values (|-2^(WIDTH-1)| = 2^(WIDTH-1) is exact).
REQ-014 DIV SHALL perform restoring division of |a|<<(FRAC_BITS+1) by |b|, one quotient bit per cycle, for N = WIDTH+FRAC_BITS+1 cycles (22 at defaults).
REQ-015 The extended quotient LSB SHALL be the round bit; sticky SHALL be (final remainder != 0); the truncated magnitude SHALL be the quotient >> 1.
REQ-016 Rounding SHALL be round-half-to-even on the magnitude: add 1 if round && (sticky || truncated[0]); the sign SHALL then be applied (symmetric about zero).
REQ-017 Saturation: positive magnitude > 2^(WIDTH-1)-1 SHALL give 2^(WIDTH-1)-1; negative magnitude > 2^(WIDTH-1) SHALL give -2^(WIDTH-1); a zero magnitude SHALL give 0, never a negative zero.
REQ-018 If b==0, the iterations SHALL still run (fixed latency) and the result SHALL be max positive for a>=0 and min negative for a<0, with div_by_zero=1.
REQ-019 Latency SHALL be fixed: data_valid high in the cycle following the (N+1)th rising edge after the accepting edge (23 edges at defaults).
REQ-020 start while busy or in ROUND SHALL be ignored; a and b SHALL not be re-sampled.
REQ-021 start in the IDLE cycle directly after ROUND SHALL be accepted, giving back-to-back throughput of one result per N+2 cycles.

Reset
REQ-022 While rst=0, the FSM SHALL be in IDLE and busy, data_valid, Div_result, and div_by_zero SHALL be 0, independent of clk.
REQ-023 Reset asserted mid-division SHALL abort the operation with no data_valid; the first start after release SHALL be handled normally.

Structure
REQ-024 WIDTH/FRAC_BITS defaults, the state encoding, and the MAX_POS/MIN_NEG constants SHALL live in a shared fixed-point package also used by the multiplier.
REQ-025 Rounding and saturation SHALL be one combinational sub-module, fixed_point_round_sat (inputs: magnitude, round, sticky, sign), reusable by other fixed-point blocks.

Verification
REQ-026 a=192 (1.5), b=64 (0.5), start -> after 23 edges, data_valid pulse, Div_result=384 (3.0), div_by_zero=0.
REQ-027 a=-128 (-1.0), b=384 (3.0) -> Div_result=-43; a=1, b=256 -> 0 (tie to even); a=3, b=256 -> 2 (tie to even).
REQ-028 a=8191, b=1 -> 8191 (saturate); a=-8192, b=1 -> -8192; a=-8192, b=-1 -> 8191.
REQ-029 a=100, b=0 -> Div_result=8191, div_by_zero=1; a=-5, b=0 -> -8192, div_by_zero=1; latency 23 edges in both cases.
REQ-030 start re-pulsed while busy is ignored; rst pulsed low at iteration 10 -> outputs 0 immediately and no data_valid; a new start after release gives the correct result.
REQ-031 Random signed a, b (including 0 and the extremes) with back-to-back starts -> every result matches a golden model applying the same round-half-to-even and saturation rules.
